// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display scan logic: FSM encoding,
// bus widths and anode polarity helpers.
package disp_pkg;

  localparam int SEL_W = 3;
  localparam int AN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  function automatic logic [AN_W-1:0] anode_off(input logic active_low);
    return active_low ? {AN_W{1'b1}} : {AN_W{1'b0}};
  endfunction

  // Map an active-high one-hot pattern onto the board polarity.
  function automatic logic [AN_W-1:0] anode_on(input logic [AN_W-1:0] onehot,
                                               input logic active_low);
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable; turns the digit select back into the
// matching anode position (all zeros when disabled).
module dec3to8 (
  input  logic       en,
  input  logic [2:0] s,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[s] = 1'b1;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with a blanking gap at
// every digit change. Define DIGIT_SCAN_DIMMING_EN to add the duty-cycle PWM input.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV      = 100000,
  parameter int BLANK_CYCLES     = 1000,
  parameter int NUM_DIGITS       = 8,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
`ifdef DIGIT_SCAN_DIMMING_EN
  input  logic [2:0] duty,
`endif
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic       digit_tick,
  output logic       frame_tick
);

  if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20) || BLANK_CYCLES < 1 ||
      BLANK_CYCLES >= REFRESH_DIV || NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_param
    $fatal(1, "digit_scan_ctrl: illegal REFRESH_DIV/BLANK_CYCLES/NUM_DIGITS");
  end

  localparam int              CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   LAST       = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   BLANK_C    = CW'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
  localparam logic [AN_W-1:0] DIGIT_MASK = AN_W'((1 << NUM_DIGITS) - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    count, count_nx;
  logic [SEL_W-1:0] sel_nx;
  logic [AN_W-1:0]  an_d, onehot;
  logic             dig_d, frame_d, dec_en, lit;

`ifdef DIGIT_SCAN_DIMMING_EN
  logic [2:0] pwm_phase, pwm_nx;
`endif

  // Outputs are registered from the next-state values, so an/sel/ticks
  // always describe the cycle the FSM is actually in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      sel        <= '0;
      an         <= anode_off(ANODE_ACTIVE_LOW);
      digit_tick <= 1'b0;
      frame_tick <= 1'b0;
`ifdef DIGIT_SCAN_DIMMING_EN
      pwm_phase  <= '0;
`endif
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      sel        <= sel_nx;
      an         <= an_d;
      digit_tick <= dig_d;
      frame_tick <= frame_d;
`ifdef DIGIT_SCAN_DIMMING_EN
      pwm_phase  <= pwm_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    sel_nx   = sel;
    if (!en || state == IDLE) begin
      state_nx = en ? BLANK : IDLE;
      count_nx = '0;
      sel_nx   = '0;
    end else begin
      if (count == LAST) begin
        count_nx = '0;
        sel_nx   = (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end else begin
        count_nx = count + 1'b1;
      end
      state_nx = (count_nx < BLANK_C) ? BLANK : ON;
    end
  end

  always_comb begin
    dig_d   = (state_nx != IDLE) && (count_nx == '0);
    frame_d = dig_d && (sel_nx == '0);
`ifdef DIGIT_SCAN_DIMMING_EN
    // Phase restarts at the first ON cycle of every slot.
    pwm_nx  = (state_nx == ON && state == ON) ? pwm_phase + 1'b1 : 3'd0;
    lit     = (pwm_nx <= duty);
`else
    lit     = 1'b1;
`endif
    dec_en  = (state_nx == ON) && lit;
    an_d    = anode_on(onehot & DIGIT_MASK, ANODE_ACTIVE_LOW);
  end

  dec3to8 u_dec (
    .en (dec_en),
    .s  (sel_nx),
    .y  (onehot)
  );

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl (REFRESH_DIV=4, BLANK_CYCLES=1,
// NUM_DIGITS=3, active-low anodes).
module tb_digit_scan_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] an;
    logic       dt;
    logic       ft;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] sel;
  logic [7:0] an;
  logic       digit_tick;
  logic       frame_tick;
`ifdef DIGIT_SCAN_DIMMING_EN
  logic [2:0] duty;
`endif

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  scan_tbl[12];
  exp_t  rst_exp;
  int    n_cmp = 0;
  int    n_bad = 0;

  digit_scan_ctrl #(
    .REFRESH_DIV      (4),
    .BLANK_CYCLES     (1),
    .NUM_DIGITS       (3),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
`ifdef DIGIT_SCAN_DIMMING_EN
    .duty       (duty),
`endif
    .sel        (sel),
    .an         (an),
    .digit_tick (digit_tick),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One DUT cycle: drive inputs, let the edge happen, queue what that edge must produce.
  task automatic cyc(input logic r, input logic e, input exp_t x, input string nm);
    reset = r;
    en    = e;
    @(posedge clk);
    exp_q.push_back(x);
    name_q.push_back(nm);
    #1;
  endtask

  task automatic scan_run(input int k0, input int k1, input string nm);
    for (int k = k0; k <= k1; k++) cyc(1'b0, 1'b1, scan_tbl[k % 12], nm);
  endtask

  // Monitor: compares every presented cycle, plus overlap and unused-anode rules.
  logic [2:0] prev_sel;
  logic       have_prev = 1'b0;
  exp_t       got, want;
  string      nm_cur;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      want   = exp_q.pop_front();
      nm_cur = name_q.pop_front();
      got    = '{sel, an, digit_tick, frame_tick};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s: got sel=%0d an=%h dt=%b ft=%b, want sel=%0d an=%h dt=%b ft=%b",
                 nm_cur, got.sel, got.an, got.dt, got.ft, want.sel, want.an, want.dt, want.ft);
      end
      if (have_prev) begin
        n_cmp++;
        if (sel !== prev_sel && an !== 8'hFF) begin
          n_bad++;
          $display("FAIL overlap: sel %0d->%0d with an=%h, want an=ff", prev_sel, sel, an);
        end
      end
      n_cmp++;
      if (an inside {8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F}) begin
        n_bad++;
        $display("FAIL unused_anode: got an=%h, want no digit >= 3 lit", an);
      end
      prev_sel  = sel;
      have_prev = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_exp     = '{3'd0, 8'hFF, 1'b0, 1'b0};
    scan_tbl[0]  = '{3'd0, 8'hFF, 1'b1, 1'b1};
    scan_tbl[1]  = '{3'd0, 8'hFE, 1'b0, 1'b0};
    scan_tbl[2]  = '{3'd0, 8'hFE, 1'b0, 1'b0};
    scan_tbl[3]  = '{3'd0, 8'hFE, 1'b0, 1'b0};
    scan_tbl[4]  = '{3'd1, 8'hFF, 1'b1, 1'b0};
    scan_tbl[5]  = '{3'd1, 8'hFD, 1'b0, 1'b0};
    scan_tbl[6]  = '{3'd1, 8'hFD, 1'b0, 1'b0};
    scan_tbl[7]  = '{3'd1, 8'hFD, 1'b0, 1'b0};
    scan_tbl[8]  = '{3'd2, 8'hFF, 1'b1, 1'b0};
    scan_tbl[9]  = '{3'd2, 8'hFB, 1'b0, 1'b0};
    scan_tbl[10] = '{3'd2, 8'hFB, 1'b0, 1'b0};
    scan_tbl[11] = '{3'd2, 8'hFB, 1'b0, 1'b0};
`ifdef DIGIT_SCAN_DIMMING_EN
    duty = 3'd7;
`endif
    reset = 1'b1;
    en    = 1'b1;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, rst_exp, "reset_hold");

    // Long scan: first 13 cycles are the basic sequence, the rest soak the overlap rules.
    scan_run(0, 999, "scan");

    // Reach slot 1 count 2, then drop en.
    scan_run(1000, 1002, "scan_to_drop");
    cyc(1'b0, 1'b0, rst_exp, "en_drop");
    cyc(1'b0, 1'b0, rst_exp, "en_low_idle");
    scan_run(0, 9, "reenable");

    // Cycle 9 above is sel=2 mid-ON; reset wins over en.
    cyc(1'b1, 1'b1, rst_exp, "reset_mid_on");
    scan_run(0, 12, "after_reset");

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
